// File: rtl/ac97_pkg.sv
// Shared AC'97 frame geometry, tag bit positions and the outgoing frame packer.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = 20;
  localparam int TAG_W      = 16;
  localparam int PAYLOAD_W  = TAG_W + 4 * SLOT_W;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [SLOT_W-1:0] slot_t;

  localparam cnt_t SLOT0_START = cnt_t'(0);
  localparam cnt_t SLOT1_START = cnt_t'(16);
  localparam cnt_t SLOT2_START = cnt_t'(36);
  localparam cnt_t SLOT3_START = cnt_t'(56);
  localparam cnt_t SLOT4_START = cnt_t'(76);

  localparam int TAG_READY    = 15;
  localparam int TAG_CMD_ADDR = 14;
  localparam int TAG_CMD_DATA = 13;
  localparam int TAG_PCM_L    = 12;
  localparam int TAG_PCM_R    = 11;

  typedef struct packed {
    logic        cmd;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        pcm_valid;
    slot_t       left;
    slot_t       right;
  } frame_t;

  // Slots 0..4 concatenated MSB first, in transmit order.
  function automatic logic [PAYLOAD_W-1:0] pack_frame(input frame_t f);
    logic [TAG_W-1:0] tag;
    slot_t            s1;
    slot_t            s2;
    tag               = '0;
    tag[TAG_CMD_ADDR] = f.cmd;
    tag[TAG_CMD_DATA] = f.cmd && !f.rw;
    tag[TAG_PCM_L]    = f.pcm_valid;
    tag[TAG_PCM_R]    = f.pcm_valid;
    tag[TAG_READY]    = |tag[TAG_CMD_ADDR:TAG_PCM_R];
    s1                = {f.rw, f.addr, 12'b0};
    s2                = (f.cmd && !f.rw) ? {f.wdata, 4'b0} : '0;
    return {tag, s1, s2, f.left, f.right};
  endfunction

endpackage

// File: rtl/ac97_link_controller_if.sv
// Command, read-back and PCM sample handshakes between the synth core and the link controller.
interface ac97_link_controller_if #(parameter int PCM_W = 20) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rw;
  logic [6:0]       cmd_addr;
  logic [15:0]      cmd_wdata;
  logic             rd_valid;
  logic [6:0]       rd_addr;
  logic [15:0]      rd_data;
  logic [PCM_W-1:0] pcm_left;
  logic [PCM_W-1:0] pcm_right;
  logic             pcm_valid;
  logic             frame_tick;
  logic             codec_ready;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, pcm_left, pcm_right, pcm_valid,
    input  cmd_ready, rd_valid, rd_addr, rd_data, frame_tick, codec_ready
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, pcm_left, pcm_right, pcm_valid,
    output cmd_ready, rd_valid, rd_addr, rd_data, frame_tick, codec_ready
  );

endinterface

// File: rtl/ac97_rx_deframer.sv
// Deframes SDATA_IN against the shared bit counter: codec-ready flag and register read-back.
module ac97_rx_deframer
  import ac97_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  cnt_t        bit_cnt,
  input  logic        sdata_in,
  output logic        rd_valid,
  output logic [6:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        codec_ready
);

  localparam cnt_t READY_POS  = cnt_t'(TAG_W - 1 - TAG_READY);
  localparam cnt_t CMD_POS    = cnt_t'(TAG_W - 1 - TAG_CMD_ADDR);
  localparam cnt_t DATA_POS   = cnt_t'(TAG_W - 1 - TAG_CMD_DATA);
  localparam cnt_t ADDR_FIRST = SLOT1_START + cnt_t'(1);
  localparam cnt_t ADDR_LAST  = SLOT1_START + cnt_t'(7);
  localparam cnt_t DATA_LAST  = SLOT2_START + cnt_t'(15);
  // Registered outputs change on this edge so rd_valid is high while bit_cnt == SLOT3_START.
  localparam cnt_t CAPTURE_AT = SLOT3_START - cnt_t'(1);

  logic        codec_ready_q, codec_ready_d;
  logic        tag_cmd_q, tag_cmd_d;
  logic        tag_data_q, tag_data_d;
  logic [6:0]  addr_sh_q, addr_sh_d;
  logic [15:0] data_sh_q, data_sh_d;
  logic        rd_valid_q, rd_valid_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [15:0] rd_data_q, rd_data_d;

  always_comb begin
    codec_ready_d = codec_ready_q;
    tag_cmd_d     = tag_cmd_q;
    tag_data_d    = tag_data_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;

    if (bit_cnt == READY_POS) codec_ready_d = sdata_in;
    if (bit_cnt == CMD_POS)   tag_cmd_d     = sdata_in;
    if (bit_cnt == DATA_POS)  tag_data_d    = sdata_in;
    if (bit_cnt >= ADDR_FIRST && bit_cnt <= ADDR_LAST)
      addr_sh_d = {addr_sh_q[5:0], sdata_in};
    if (bit_cnt >= SLOT2_START && bit_cnt <= DATA_LAST)
      data_sh_d = {data_sh_q[14:0], sdata_in};

    if (bit_cnt == CAPTURE_AT && tag_cmd_q && tag_data_q) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = addr_sh_q;
      rd_data_d  = data_sh_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codec_ready_q <= 1'b0;
      tag_cmd_q     <= 1'b0;
      tag_data_q    <= 1'b0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
    end else begin
      codec_ready_q <= codec_ready_d;
      tag_cmd_q     <= tag_cmd_d;
      tag_data_q    <= tag_data_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign codec_ready = codec_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;

endmodule

// File: rtl/ac97_link_controller.sv
// AC'97 frame sequencer: SYNC generation, command/PCM framing onto SDATA_OUT, receive deframing.
module ac97_link_controller
  import ac97_pkg::*;
#(
  parameter int PCM_W = 20
) (
  input  logic                   BIT_CLK,
  input  logic                   SYSTEM_RESET,
  input  logic                   SDATA_IN,
  output logic                   SYNC,
  output logic                   SDATA_OUT,
  ac97_link_controller_if.slave  bus
);

  cnt_t                 bit_cnt_q, bit_cnt_d;
  logic                 sync_q, sync_d;
  logic                 sdata_out_q, sdata_out_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 pending_q, pending_d;
  logic                 pend_rw_q, pend_rw_d;
  logic [6:0]           pend_addr_q, pend_addr_d;
  logic [15:0]          pend_wdata_q, pend_wdata_d;
  logic [PAYLOAD_W-1:0] tx_sh_q, tx_sh_d;
  frame_t               frame_nxt;
  logic                 latch;
  logic                 accept;

  always_comb begin
    bit_cnt_d = bit_cnt_q + cnt_t'(1);
    latch     = (bit_cnt_q == '1);
    accept    = bus.cmd_valid && !pending_q;

    frame_nxt           = '0;
    frame_nxt.cmd       = pending_q;
    frame_nxt.rw        = pending_q && pend_rw_q;
    frame_nxt.addr      = pending_q ? pend_addr_q : '0;
    frame_nxt.wdata     = pending_q ? pend_wdata_q : '0;
    frame_nxt.pcm_valid = bus.pcm_valid;
    if (bus.pcm_valid) begin
      frame_nxt.left  = SLOT_W'(bus.pcm_left) << (SLOT_W - PCM_W);
      frame_nxt.right = SLOT_W'(bus.pcm_right) << (SLOT_W - PCM_W);
    end

    // A command accepted on the latch edge itself stays pending for the following frame.
    pending_d    = latch ? 1'b0 : pending_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    if (accept) begin
      pending_d    = 1'b1;
      pend_rw_d    = bus.cmd_rw;
      pend_addr_d  = bus.cmd_addr;
      pend_wdata_d = bus.cmd_wdata;
    end

    // The shift register is the frame store; zeros shift in behind slot 4.
    tx_sh_d      = latch ? pack_frame(frame_nxt) : {tx_sh_q[PAYLOAD_W-2:0], 1'b0};
    sdata_out_d  = tx_sh_d[PAYLOAD_W-1];
    sync_d       = bit_cnt_d < SLOT1_START;
    frame_tick_d = (bit_cnt_d == '1);
  end

  always_ff @(posedge BIT_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      bit_cnt_q    <= '1;
      sync_q       <= 1'b0;
      sdata_out_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      pending_q    <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      tx_sh_q      <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      sync_q       <= sync_d;
      sdata_out_q  <= sdata_out_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      tx_sh_q      <= tx_sh_d;
    end
  end

  logic        rx_rd_valid;
  logic [6:0]  rx_rd_addr;
  logic [15:0] rx_rd_data;
  logic        rx_codec_ready;

  ac97_rx_deframer u_rx (
    .clk         (BIT_CLK),
    .rst         (SYSTEM_RESET),
    .bit_cnt     (bit_cnt_q),
    .sdata_in    (SDATA_IN),
    .rd_valid    (rx_rd_valid),
    .rd_addr     (rx_rd_addr),
    .rd_data     (rx_rd_data),
    .codec_ready (rx_codec_ready)
  );

  assign SYNC            = sync_q;
  assign SDATA_OUT       = sdata_out_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.cmd_ready   = !pending_q;
  assign bus.rd_valid    = rx_rd_valid;
  assign bus.rd_addr     = rx_rd_addr;
  assign bus.rd_data     = rx_rd_data;
  assign bus.codec_ready = rx_codec_ready;

endmodule

// File: tb/tb_ac97_link_controller.sv
// Directed bench for ac97_link_controller: framing, command handshake, PCM slots, read-back, reset.
module tb_ac97_link_controller;

  logic BIT_CLK = 1'b0;
  logic SYSTEM_RESET = 1'b1;
  logic SDATA_IN = 1'b0;
  logic SYNC, SDATA_OUT;
  logic sdata_in16 = 1'b0;
  logic sync16, sdata_out16;

  int total = 0;
  int bad = 0;
  logic [7:0] tb_cnt = 8'hFF;

  ac97_link_controller_if #(.PCM_W(20)) bus ();
  ac97_link_controller_if #(.PCM_W(16)) bus16 ();

  ac97_link_controller #(.PCM_W(20)) dut (
    .BIT_CLK(BIT_CLK), .SYSTEM_RESET(SYSTEM_RESET), .SDATA_IN(SDATA_IN),
    .SYNC(SYNC), .SDATA_OUT(SDATA_OUT), .bus(bus)
  );

  ac97_link_controller #(.PCM_W(16)) dut16 (
    .BIT_CLK(BIT_CLK), .SYSTEM_RESET(SYSTEM_RESET), .SDATA_IN(sdata_in16),
    .SYNC(sync16), .SDATA_OUT(sdata_out16), .bus(bus16)
  );

  always #5 BIT_CLK = ~BIT_CLK;

  // Bench-side frame position, used only to schedule stimulus.
  always @(posedge BIT_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) tb_cnt <= 8'hFF;
    else              tb_cnt <= tb_cnt + 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cnt(input int k);
    int n;
    n = 0;
    do begin
      @(negedge BIT_CLK);
      n++;
    end while (tb_cnt != k && n < 300);
    if (tb_cnt != k) begin
      total++; bad++;
      $display("FAIL wait_cnt: cnt=%0d required %0d", tb_cnt, k);
    end
  endtask

  // Starts at the current negedge (bit_cnt 0) and collects slots 0..4 from both instances.
  task automatic read_frame(output logic [95:0] f, output logic [95:0] f16);
    for (int i = 0; i < 96; i++) begin
      f[95-i]   = SDATA_OUT;
      f16[95-i] = sdata_out16;
      if (i < 95) @(negedge BIT_CLK);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge BIT_CLK);
    total++; if (SYNC !== 1'b0) begin bad++; $display("FAIL rst_sync: got %b want 0", SYNC); end
    total++; if (SDATA_OUT !== 1'b0) begin bad++; $display("FAIL rst_sdo: got %b want 0", SDATA_OUT); end
    total++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", bus.frame_tick); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rdv: got %b want 0", bus.rd_valid); end
    total++; if (bus.rd_addr !== 7'h00) begin bad++; $display("FAIL rst_rdaddr: got %h want 00", bus.rd_addr); end
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL rst_rddata: got %h want 0000", bus.rd_data); end
    total++; if (bus.codec_ready !== 1'b0) begin bad++; $display("FAIL rst_cready: got %b want 0", bus.codec_ready); end
  endtask

  task automatic test_idle;
    int sync_err, tick_err, sdo_err, sync_hi, ticks, pos;
    logic first_sync;
    sync_err = 0; tick_err = 0; sdo_err = 0; sync_hi = 0; ticks = 0;
    first_sync = 1'b0;
    SYSTEM_RESET = 1'b0;
    for (int c = 0; c < 512; c++) begin
      @(negedge BIT_CLK);
      pos = c % 256;
      if (c == 0) first_sync = SYNC;
      if (SYNC !== (pos < 16)) sync_err++;
      if (bus.frame_tick !== (pos == 255)) tick_err++;
      if (SDATA_OUT !== 1'b0) sdo_err++;
      if (SYNC === 1'b1) sync_hi++;
      if (bus.frame_tick === 1'b1) ticks++;
    end
    total++; if (first_sync !== 1'b1) begin bad++; $display("FAIL idle_first_sync: got %b want 1", first_sync); end
    total++; if (sync_err != 0) begin bad++; $display("FAIL idle_sync_pos: got %0d wrong cycles want 0", sync_err); end
    total++; if (sync_hi != 32) begin bad++; $display("FAIL idle_sync_count: got %0d want 32", sync_hi); end
    total++; if (tick_err != 0) begin bad++; $display("FAIL idle_tick_pos: got %0d wrong cycles want 0", tick_err); end
    total++; if (ticks != 2) begin bad++; $display("FAIL idle_tick_count: got %0d want 2", ticks); end
    total++; if (sdo_err != 0) begin bad++; $display("FAIL idle_sdo: got %0d nonzero bits want 0", sdo_err); end
  endtask

  task automatic test_write;
    logic [95:0] f, f16;
    wait_cnt(10);
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 7'h02; bus.cmd_wdata = 16'h0808;
    wait_cnt(11);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_drop: got %b want 0", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    wait_cnt(255);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_held: got %b want 0", bus.cmd_ready); end
    wait_cnt(0);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_back: got %b want 1", bus.cmd_ready); end
    read_frame(f, f16);
    total++; if (f !== {16'hE000, 20'h02000, 20'h08080, 40'h0}) begin bad++; $display("FAIL wr_frame: got %h want %h", f, {16'hE000, 20'h02000, 20'h08080, 40'h0}); end
  endtask

  task automatic test_pcm;
    logic [95:0] f, f16;
    wait_cnt(200);
    bus.pcm_valid = 1'b1; bus.pcm_left = 20'hABCDE; bus.pcm_right = 20'h12345;
    bus16.pcm_valid = 1'b1; bus16.pcm_left = 16'h8001; bus16.pcm_right = 16'hFFFF;
    wait_cnt(255);
    total++; if (bus.frame_tick !== 1'b1) begin bad++; $display("FAIL pcm_tick: got %b want 1", bus.frame_tick); end
    wait_cnt(0);
    bus.pcm_valid = 1'b0; bus.pcm_left = 20'h55555; bus.pcm_right = 20'h55555;
    bus16.pcm_valid = 1'b0;
    read_frame(f, f16);
    total++; if (f !== {16'h9800, 40'h0, 20'hABCDE, 20'h12345}) begin bad++; $display("FAIL pcm_frame20: got %h want %h", f, {16'h9800, 40'h0, 20'hABCDE, 20'h12345}); end
    total++; if (f16 !== {16'h9800, 40'h0, 20'h80010, 20'hFFFF0}) begin bad++; $display("FAIL pcm_frame16: got %h want %h", f16, {16'h9800, 40'h0, 20'h80010, 20'hFFFF0}); end
    wait_cnt(0);
    read_frame(f, f16);
    total++; if (f !== 96'h0) begin bad++; $display("FAIL pcm_invalid20: got %h want 0", f); end
    total++; if (f16 !== 96'h0) begin bad++; $display("FAIL pcm_invalid16: got %h want 0", f16); end
  endtask

  task automatic test_cmd_at_wrap;
    logic [95:0] f, f16;
    wait_cnt(255);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_pre: got %b want 1", bus.cmd_ready); end
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 7'h11; bus.cmd_wdata = 16'hBEEF;
    wait_cnt(0);
    bus.cmd_valid = 1'b0;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wrap_ready_drop: got %b want 0", bus.cmd_ready); end
    read_frame(f, f16);
    total++; if (f !== 96'h0) begin bad++; $display("FAIL wrap_missed_frame: got %h want 0", f); end
    wait_cnt(255);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wrap_ready_extra: got %b want 0", bus.cmd_ready); end
    wait_cnt(0);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_back: got %b want 1", bus.cmd_ready); end
    read_frame(f, f16);
    total++; if (f !== {16'hE000, 20'h11000, 20'hBEEF0, 40'h0}) begin bad++; $display("FAIL wrap_frame: got %h want %h", f, {16'hE000, 20'h11000, 20'hBEEF0, 40'h0}); end
  endtask

  task automatic test_readback;
    logic [95:0] cf;
    int rv_err;
    cf = {16'hE000, 20'h82000, 20'h1F1F0, 40'h0};
    rv_err = 0;
    total++; if (bus.codec_ready !== 1'b0) begin bad++; $display("FAIL rb_cready_pre: got %b want 0", bus.codec_ready); end
    wait_cnt(0);
    for (int i = 0; i < 96; i++) begin
      if (bus.rd_valid !== (i == 56)) rv_err++;
      if (i == 5) begin
        total++; if (bus.codec_ready !== 1'b1) begin bad++; $display("FAIL rb_cready: got %b want 1", bus.codec_ready); end
      end
      if (i == 56) begin
        total++; if (bus.rd_addr !== 7'h02) begin bad++; $display("FAIL rb_addr: got %h want 02", bus.rd_addr); end
        total++; if (bus.rd_data !== 16'h1F1F) begin bad++; $display("FAIL rb_data: got %h want 1f1f", bus.rd_data); end
      end
      SDATA_IN = cf[95-i];
      @(negedge BIT_CLK);
    end
    SDATA_IN = 1'b0;
    total++; if (rv_err != 0) begin bad++; $display("FAIL rb_valid_pulse: got %0d wrong cycles want 0", rv_err); end
    wait_cnt(200);
    total++; if (bus.rd_data !== 16'h1F1F) begin bad++; $display("FAIL rb_data_hold: got %h want 1f1f", bus.rd_data); end
  endtask

  task automatic test_reset_mid;
    logic [95:0] f, f16;
    wait_cnt(20);
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 7'h05; bus.cmd_wdata = 16'h0000;
    wait_cnt(21);
    bus.cmd_valid = 1'b0;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_pre: got %b want 0", bus.cmd_ready); end
    wait_cnt(40);
    SYSTEM_RESET = 1'b1;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.cmd_ready); end
    total++; if (SDATA_OUT !== 1'b0) begin bad++; $display("FAIL mid_sdo: got %b want 0", SDATA_OUT); end
    total++; if (bus.rd_addr !== 7'h00) begin bad++; $display("FAIL mid_rdaddr: got %h want 00", bus.rd_addr); end
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL mid_rddata: got %h want 0000", bus.rd_data); end
    total++; if (bus.codec_ready !== 1'b0) begin bad++; $display("FAIL mid_cready: got %b want 0", bus.codec_ready); end
    repeat (2) @(negedge BIT_CLK);
    SYSTEM_RESET = 1'b0;
    wait_cnt(0);
    total++; if (SYNC !== 1'b1) begin bad++; $display("FAIL mid_first_sync: got %b want 1", SYNC); end
    read_frame(f, f16);
    total++; if (f !== 96'h0) begin bad++; $display("FAIL mid_cmd_dropped: got %h want 0", f); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.pcm_valid = 1'b0; bus.pcm_left = '0; bus.pcm_right = '0;
    bus16.cmd_valid = 1'b0; bus16.cmd_rw = 1'b0; bus16.cmd_addr = '0; bus16.cmd_wdata = '0;
    bus16.pcm_valid = 1'b0; bus16.pcm_left = '0; bus16.pcm_right = '0;
    test_reset();
    test_idle();
    test_write();
    test_pcm();
    test_cmd_at_wrap();
    test_readback();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
